// File: rtl/if_stage_pc_unit_pkg.sv
// Shared definitions for the instruction-fetch PC unit: default widths,
// the NOP encoding and the next-PC source selection.
package if_stage_pc_unit_pkg;

    localparam int DEF_PC_LEN          = 12;
    localparam int DEF_INSTRUCTION_LEN = 19;
    localparam int DEF_OFFSET_LEN      = 8;
    localparam int DEF_STACK_DEPTH     = 8;

    // A NOP is the all-zero instruction word.
    localparam logic [DEF_INSTRUCTION_LEN-1:0] NOP_INSTRUCTION = '0;

    typedef enum logic [1:0] {
        PC_PLUS1  = 2'd0,
        PC_OFFSET = 2'd1,
        PC_CONST  = 2'd2,
        PC_STACK  = 2'd3
    } pc_sel_e;

    // Selects are meant to be one-hot; if several are high the stack wins,
    // then the constant, then the offset. Nothing high means sequential.
    function automatic pc_sel_e pc_sel_encode(
        input logic sel_plus1,
        input logic sel_offset,
        input logic sel_const,
        input logic sel_stack
    );
        pc_sel_e sel;
        sel = PC_PLUS1;
        if (sel_stack) begin
            sel = PC_STACK;
        end else if (sel_const) begin
            sel = PC_CONST;
        end else if (sel_offset) begin
            sel = PC_OFFSET;
        end else if (sel_plus1) begin
            sel = PC_PLUS1;
        end
        return sel;
    endfunction

endpackage

// File: rtl/if_stage_pc_unit_return_stack.sv
// Hardware return-address stack. sp counts valid entries (0..STACK_DEPTH);
// the top entry is read combinationally so a return can use it in the same
// cycle it is popped. Illegal operations are ignored and latch sticky flags.
module if_stage_pc_unit_return_stack
    import if_stage_pc_unit_pkg::*;
#(
    parameter int PC_LEN      = DEF_PC_LEN,
    parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [PC_LEN-1:0] push_data,
    output logic [PC_LEN-1:0] top_data,
    output logic              overflow,
    output logic              underflow,
    output logic              conflict
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = $clog2(STACK_DEPTH);

    logic [PC_LEN-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp;
    logic              full;
    logic              empty;
    logic              do_push;
    logic              do_pop;

    // Decode which operation really happens and present the top entry.
    always_comb begin
        full     = (sp == SP_W'(STACK_DEPTH));
        empty    = (sp == '0);
        do_push  = push && !pop && !full;
        do_pop   = pop && !push && !empty;
        top_data = '0;
        if (!empty) begin
            top_data = mem[IDX_W'(sp - SP_W'(1))];
        end
    end

    // Storage write; contents need no reset since sp bounds every read.
    always_ff @(posedge clk) begin
        if (!rst && do_push) begin
            mem[sp[IDX_W-1:0]] <= push_data;
        end
    end

    // Stack pointer and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            conflict  <= 1'b0;
        end else begin
            if (do_push) begin
                sp <= sp + SP_W'(1);
            end else if (do_pop) begin
                sp <= sp - SP_W'(1);
            end
            if (push && !pop && full) begin
                overflow <= 1'b1;
            end
            if (pop && !push && empty) begin
                underflow <= 1'b1;
            end
            if (push && pop) begin
                conflict <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/if_stage_pc_unit.sv
// Instruction-fetch stage: owns the PC, picks the next PC from redirects
// resolved in EX, and registers the fetched word into the IF/ID outputs.
// A redirect flushes the wrong-path fetch and beats a stall.
module if_stage_pc_unit
    import if_stage_pc_unit_pkg::*;
#(
    parameter int PC_LEN          = DEF_PC_LEN,
    parameter int INSTRUCTION_LEN = DEF_INSTRUCTION_LEN,
    parameter int OFFSET_LEN      = DEF_OFFSET_LEN,
    parameter int STACK_DEPTH     = DEF_STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       sel_PC_src_plus1,
    input  logic                       sel_PC_src_offset,
    input  logic                       sel_PC_src_const,
    input  logic                       sel_PC_src_stack,
    input  logic [PC_LEN-1:0]          ex_pc,
    input  logic [OFFSET_LEN-1:0]      branch_offset,
    input  logic [PC_LEN-1:0]          jump_const,
    input  logic                       push_stack,
    input  logic                       pop_stack,
    output logic [PC_LEN-1:0]          imem_addr,
    input  logic [INSTRUCTION_LEN-1:0] imem_rdata,
    output logic [INSTRUCTION_LEN-1:0] PR1_instruction,
    output logic [PC_LEN-1:0]          PR1_pc_plus1,
    output logic                       PR1_valid,
    output logic                       stack_overflow,
    output logic                       stack_underflow,
    output logic                       stack_conflict
);

    logic [PC_LEN-1:0] pc;
    logic [PC_LEN-1:0] pc_plus1;
    logic [PC_LEN-1:0] ex_pc_plus1;
    logic [PC_LEN-1:0] offset_target;
    logic [PC_LEN-1:0] stack_top;
    logic [PC_LEN-1:0] target;
    logic              redirect;
    pc_sel_e           sel;

    assign imem_addr = pc;

    if_stage_pc_unit_return_stack #(
        .PC_LEN      (PC_LEN),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_return_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (push_stack),
        .pop       (pop_stack),
        .push_data (ex_pc_plus1),
        .top_data  (stack_top),
        .overflow  (stack_overflow),
        .underflow (stack_underflow),
        .conflict  (stack_conflict)
    );

    // Next-PC selection; all sums wrap modulo 2^PC_LEN.
    always_comb begin
        pc_plus1      = pc + PC_LEN'(1);
        ex_pc_plus1   = ex_pc + PC_LEN'(1);
        offset_target = ex_pc + {{(PC_LEN-OFFSET_LEN){branch_offset[OFFSET_LEN-1]}}, branch_offset};
        sel           = pc_sel_encode(sel_PC_src_plus1, sel_PC_src_offset,
                                      sel_PC_src_const, sel_PC_src_stack);
        redirect      = (sel != PC_PLUS1);
        target        = pc_plus1;
        case (sel)
            PC_OFFSET: target = offset_target;
            PC_CONST:  target = jump_const;
            PC_STACK:  target = stack_top;
            default:   target = pc_plus1;
        endcase
    end

    // PC register and IF/ID pipeline register with flush and stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc              <= '0;
            PR1_instruction <= '0;
            PR1_pc_plus1    <= '0;
            PR1_valid       <= 1'b0;
        end else if (redirect) begin
            pc              <= target;
            PR1_instruction <= INSTRUCTION_LEN'(NOP_INSTRUCTION);
            PR1_valid       <= 1'b0;
        end else if (!stall) begin
            pc              <= pc_plus1;
            PR1_instruction <= imem_rdata;
            PR1_pc_plus1    <= pc_plus1;
            PR1_valid       <= 1'b1;
        end
    end

endmodule
